// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: instruction layout, opcodes and FSM states.
// An instruction word is {opcode[27:24], imm[23:0]}; a NOP's imm is its delay count.
package fetch_sequencer_pkg;

    localparam int unsigned AddrWidth  = 16;
    localparam int unsigned InstrWidth = 28;
    localparam int unsigned OpWidth    = 4;
    localparam int unsigned ImmWidth   = 24;

    localparam logic [OpWidth-1:0] OpNop   = 4'h0;
    localparam logic [OpWidth-1:0] OpAdd   = 4'h1;
    localparam logic [OpWidth-1:0] OpSub   = 4'h2;
    localparam logic [OpWidth-1:0] OpAnd   = 4'h3;
    localparam logic [OpWidth-1:0] OpOr    = 4'h4;
    localparam logic [OpWidth-1:0] OpXor   = 4'h5;
    localparam logic [OpWidth-1:0] OpLoad  = 4'h6;
    localparam logic [OpWidth-1:0] OpStore = 4'h7;
    localparam logic [OpWidth-1:0] OpJump  = 4'h8;

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StWait  = 2'd1,
        StFlush = 2'd2
    } fetch_state_e;

    function automatic logic [OpWidth-1:0] instr_opcode(input logic [InstrWidth-1:0] instr);
        return instr[InstrWidth-1 -: OpWidth];
    endfunction

    function automatic logic [ImmWidth-1:0] instr_imm(input logic [InstrWidth-1:0] instr);
        return instr[ImmWidth-1:0];
    endfunction

    // True only for NOPs that actually request a delay.
    function automatic logic is_delay_nop(input logic [InstrWidth-1:0] instr);
        return (instr_opcode(instr) == OpNop) && (instr_imm(instr) != '0);
    endfunction

endpackage

// File: rtl/fetch_sequencer_delay_counter.sv
// Down-counter that times the WAIT state after a delaying NOP.
// done_o flags the last wait cycle (count == 1).
module delay_counter
    import fetch_sequencer_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic                dec_en_i,
    input  logic [ImmWidth-1:0] load_val_i,
    output logic                done_o
);

    logic [ImmWidth-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_en_i && (count_q != '0)) begin
            count_d = count_q - ImmWidth'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == ImmWidth'(1));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the PC through ROM, issues registered instructions,
// inserts NOP-requested wait cycles and flushes one cycle on a branch redirect.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter bit          P_DELAY_EN = 1'b1,
    parameter logic [15:0] P_RESET_PC = 16'd0
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [15:0] oAddress,
    input  logic [27:0] iInstruction,
    input  logic        iStall,
    input  logic        iBranchTaken,
    input  logic [15:0] iBranchTarget,
    output logic [27:0] oInstruction,
    output logic        oValid,
    output logic [15:0] oPC
);

    fetch_state_e    state_q, state_d;
    logic [15:0]     pc_q, pc_d;
    logic [27:0]     instr_q, instr_d;
    logic [15:0]     opc_q, opc_d;
    logic            valid_q, valid_d;

    logic                cnt_load;
    logic                cnt_dec;
    logic [ImmWidth-1:0] cnt_load_val;
    logic                cnt_done;

    delay_counter u_delay_counter (
        .clk_i      (Clock),
        .rst_i      (Reset),
        .load_i     (cnt_load),
        .dec_en_i   (cnt_dec),
        .load_val_i (cnt_load_val),
        .done_o     (cnt_done)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        opc_d        = opc_q;
        valid_d      = valid_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = '0;

        if (iBranchTaken) begin
            // Redirect wins over stall and any state; the word at the old PC is dropped.
            pc_d     = iBranchTarget;
            valid_d  = 1'b0;
            cnt_load = 1'b1;
            state_d  = StFlush;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (!iStall) begin
                        instr_d = iInstruction;
                        opc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 16'd1;
                        if (P_DELAY_EN && is_delay_nop(iInstruction)) begin
                            cnt_load     = 1'b1;
                            cnt_load_val = instr_imm(iInstruction);
                            state_d      = StWait;
                        end
                    end
                end
                StWait: begin
                    // The NOP stays visible on oInstruction but is never re-issued while waiting.
                    valid_d = 1'b0;
                    if (!iStall) begin
                        cnt_dec = 1'b1;
                        if (cnt_done) begin
                            state_d = StFetch;
                        end
                    end
                end
                StFlush: begin
                    // Always a single bubble so the target issues two cycles after the branch.
                    valid_d = 1'b0;
                    state_d = StFetch;
                end
                default: begin
                    valid_d = 1'b0;
                    state_d = StFetch;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= StFetch;
            pc_q    <= P_RESET_PC;
            instr_q <= {OpNop, {ImmWidth{1'b0}}};
            opc_q   <= 16'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
            valid_q <= valid_d;
        end
    end

    assign oAddress     = pc_q;
    assign oInstruction = instr_q;
    assign oPC          = opc_q;
    assign oValid       = valid_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a scoreboard of expected issues (PC, word, and
// the number of bubble cycles before it) plus per-scenario inline checks.
module tb_fetch_sequencer;

    typedef struct {
        logic [15:0] pc;
        logic [27:0] instr;
        int          gap;
    } exp_t;

    logic        Clock;
    logic        Reset;
    logic [15:0] oAddress;
    logic [27:0] iInstruction;
    logic        iStall;
    logic        iBranchTaken;
    logic [15:0] iBranchTarget;
    logic [27:0] oInstruction;
    logic        oValid;
    logic [15:0] oPC;

    logic [27:0] rom [0:65535];
    exp_t        exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    fetch_sequencer dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .oAddress      (oAddress),
        .iInstruction  (iInstruction),
        .iStall        (iStall),
        .iBranchTaken  (iBranchTaken),
        .iBranchTarget (iBranchTarget),
        .oInstruction  (oInstruction),
        .oValid        (oValid),
        .oPC           (oPC)
    );

    assign iInstruction = rom[oAddress];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [27:0] add_word(input logic [15:0] a);
        return {4'h1, 8'h00, a};
    endfunction

    function automatic logic [27:0] nop_word(input logic [23:0] n);
        return {4'h0, n};
    endfunction

    task automatic rom_fill();
        for (int a = 0; a < 65536; a++) begin
            rom[a] = add_word(a[15:0]);
        end
    endtask

    task automatic push(input logic [15:0] pc, input int gap);
        exp_t e;
        e.pc    = pc;
        e.instr = rom[pc];
        e.gap   = gap;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge Clock);
        #2;
    endtask

    // Scoreboard: a new issue is an oValid=1 sample not merely held by a stall.
    initial begin : scoreboard
        logic st, br;
        int   gap;
        exp_t e;
        gap = 0;
        forever begin
            @(posedge Clock);
            st = iStall;
            br = iBranchTaken;
            #1;
            if (Reset) begin
                gap = 0;
            end else if (oValid && !(st && !br)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_issue: got oPC=%h, required no issue", oPC);
                end else begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if (oPC !== e.pc) $display("FAIL issue_pc: got %h, required %h", oPC, e.pc);
                    else n_pass++;
                    n_checks++;
                    if (oInstruction !== e.instr)
                        $display("FAIL issue_instr@%h: got %h, required %h", e.pc, oInstruction,
                                 e.instr);
                    else n_pass++;
                    n_checks++;
                    if (gap !== e.gap)
                        $display("FAIL issue_gap@%h: got %0d, required %0d", e.pc, gap, e.gap);
                    else n_pass++;
                end
                gap = 0;
            end else if (!oValid) begin
                gap++;
            end
        end
    end

    task automatic test_reset();
        Reset = 1'b1;
        step();
        n_checks++;
        if (oValid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", oValid);
        else n_pass++;
        n_checks++;
        if (oPC !== 16'h0000) $display("FAIL reset_opc: got %h, required 0000", oPC);
        else n_pass++;
        n_checks++;
        if (oInstruction !== 28'h0) $display("FAIL reset_instr: got %h, required 0", oInstruction);
        else n_pass++;
        n_checks++;
        if (oAddress !== 16'h0000) $display("FAIL reset_addr: got %h, required 0000", oAddress);
        else n_pass++;
    endtask

    task automatic test_free_run();
        rom_fill();
        for (int p = 0; p < 6; p++) push(16'(p), 0);
        Reset = 1'b0;
        step();
        n_checks++;
        if (oValid !== 1'b1 || oPC !== 16'd0)
            $display("FAIL first_issue: got valid=%b pc=%h, required valid=1 pc=0000", oValid, oPC);
        else n_pass++;
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) step();
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL free_run_drain: got %0d left, required 0", exp_q.size());
        else n_pass++;
        Reset = 1'b1;
        step();
    endtask

    task automatic test_nop_delay();
        rom_fill();
        rom[1] = nop_word(24'd5);
        push(16'd0, 0); push(16'd1, 0); push(16'd2, 5); push(16'd3, 0);
        Reset = 1'b0;
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) step();
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL nop_drain: got %0d left, required 0", exp_q.size());
        else n_pass++;
        Reset = 1'b1;
        step();
    endtask

    task automatic test_nop_zero();
        rom_fill();
        rom[1] = nop_word(24'd0);
        push(16'd0, 0); push(16'd1, 0); push(16'd2, 0); push(16'd3, 0);
        Reset = 1'b0;
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) step();
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL nop0_drain: got %0d left, required 0", exp_q.size());
        else n_pass++;
        Reset = 1'b1;
        step();
    endtask

    task automatic test_branch_stall();
        rom_fill();
        push(16'd0, 0); push(16'd1, 0); push(16'd2, 0); push(16'd6, 2); push(16'd7, 0);
        Reset = 1'b0;
        step(); step(); step();
        iBranchTaken  = 1'b1;
        iBranchTarget = 16'd6;
        iStall        = 1'b1;
        step();
        iBranchTaken = 1'b0;
        iStall       = 1'b0;
        n_checks++;
        if (oValid !== 1'b0 || oAddress !== 16'd6)
            $display("FAIL branch_edge: got valid=%b addr=%h, required valid=0 addr=0006", oValid,
                     oAddress);
        else n_pass++;
        step();
        n_checks++;
        if (oValid !== 1'b0) $display("FAIL flush_valid: got %b, required 0", oValid);
        else n_pass++;
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) step();
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL branch_drain: got %0d left, required 0", exp_q.size());
        else n_pass++;
        Reset = 1'b1;
        step();
    endtask

    task automatic test_stall_in_wait();
        rom_fill();
        rom[1] = nop_word(24'd4);
        push(16'd0, 0); push(16'd1, 0); push(16'd2, 7); push(16'd3, 0);
        Reset = 1'b0;
        step(); step(); step();
        iStall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (oInstruction !== nop_word(24'd4))
                $display("FAIL wait_instr_hold: got %h, required %h", oInstruction, nop_word(24'd4));
            else n_pass++;
            n_checks++;
            if (oValid !== 1'b0 || oAddress !== 16'd2)
                $display("FAIL wait_stall_hold: got valid=%b addr=%h, required valid=0 addr=0002",
                         oValid, oAddress);
            else n_pass++;
        end
        iStall = 1'b0;
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) step();
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL stall_drain: got %0d left, required 0", exp_q.size());
        else n_pass++;
        Reset = 1'b1;
        step();
    endtask

    task automatic test_wrap();
        rom_fill();
        push(16'd0, 0); push(16'hFFFF, 2); push(16'h0000, 0); push(16'h0001, 0);
        Reset = 1'b0;
        step();
        iBranchTaken  = 1'b1;
        iBranchTarget = 16'hFFFF;
        step();
        iBranchTaken = 1'b0;
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) step();
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL wrap_drain: got %0d left, required 0", exp_q.size());
        else n_pass++;
        Reset = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_wait();
        rom_fill();
        rom[1] = nop_word(24'd10);
        push(16'd0, 0); push(16'd1, 0);
        Reset = 1'b0;
        step(); step(); step(); step();
        #3;
        Reset = 1'b1;
        #1;
        n_checks++;
        if (oValid !== 1'b0 || oPC !== 16'd0)
            $display("FAIL async_reset: got valid=%b pc=%h, required valid=0 pc=0000", oValid, oPC);
        else n_pass++;
        n_checks++;
        if (oInstruction !== 28'h0 || oAddress !== 16'd0)
            $display("FAIL async_reset_instr: got instr=%h addr=%h, required 0/0000", oInstruction,
                     oAddress);
        else n_pass++;
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL pre_reset_drain: got %0d left, required 0", exp_q.size());
        else n_pass++;
        exp_q.delete();
        step();
        rom[1] = add_word(16'd1);
        push(16'd0, 0); push(16'd1, 0); push(16'd2, 0);
        Reset = 1'b0;
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) step();
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL restart_drain: got %0d left, required 0", exp_q.size());
        else n_pass++;
        Reset = 1'b1;
        step();
    endtask

    initial begin
        Reset         = 1'b1;
        iStall        = 1'b0;
        iBranchTaken  = 1'b0;
        iBranchTarget = 16'd0;
        rom_fill();
        test_reset();
        test_free_run();
        test_nop_delay();
        test_nop_zero();
        test_branch_stall();
        test_stall_in_wait();
        test_wrap();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter P_DELAY_EN, default 1, which enables NOP-delay handling (0 = NOP is issued as a plain instruction).
REQ-002 The block SHALL have parameter P_RESET_PC, default 16'd0, the first fetch address after reset.
REQ-003 The block SHALL have port Clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port oAddress  output  16  instruction ROM address, equal to the internal PC register.
REQ-006 The block SHALL have port iInstruction  input  28  combinational ROM data for oAddress.
REQ-007 The block SHALL have port iStall  input  1  downstream hold request.
REQ-008 The block SHALL have port iBranchTaken  input  1  one-cycle redirect request.
REQ-009 The block SHALL have port iBranchTarget  input  16  redirect address, sampled when iBranchTaken=1.
REQ-010 The block SHALL have port oInstruction  output  28  registered issued instruction.
REQ-011 The block SHALL have port oValid  output  1  oInstruction is a real issue this cycle.
REQ-012 The block SHALL have port oPC  output  16  address the current oInstruction was fetched from.

Function
REQ-013 The FSM SHALL have three states: FETCH, WAIT, and FLUSH.
REQ-014 In FETCH with iStall=0 and no branch, each cycle the block SHALL register iInstruction into oInstruction, set oPC to PC and oValid to 1, and increment PC by 1.
REQ-015 Fetch-to-issue latency SHALL be one clock.
REQ-016 PC SHALL wrap from 16'hFFFF to 16'h0000.
REQ-017 While iStall=1 without a branch, PC, oInstruction, oPC, oValid, the state, and the WAIT counter SHALL all hold.
REQ-018 iBranchTaken=1 SHALL take priority over iStall and over every state.
  - The block SHALL load PC with iBranchTarget, clear oValid, clear the WAIT counter, and go to FLUSH.
REQ-019 FLUSH SHALL last exactly one cycle with oValid=0, then return to FETCH.
  - The instruction at the target SHALL issue two cycles after the branch.
REQ-020 When P_DELAY_EN=1 and the issued instruction has the NOP opcode with a nonzero low 24-bit field N:
  - the NOP SHALL issue normally with oValid=1;
  - the block SHALL then enter WAIT for exactly N cycles with oValid=0 and PC held;
  - the block SHALL return to FETCH afterwards.
REQ-021 A NOP with N=0 SHALL issue and fall through with no WAIT.
REQ-022 During WAIT, the 24-bit counter SHALL decrement only when iStall=0.
  - WAIT SHALL exit on the cycle after the counter reaches 1.
REQ-023 If iStall and iBranchTaken are asserted in the same cycle, the branch SHALL win.

Reset
REQ-024 Reset=1 SHALL asynchronously force the following at any time, including mid-WAIT and mid-FLUSH:
  - PC = P_RESET_PC;
  - oInstruction = all-zero NOP;
  - oPC = 0;
  - oValid = 0;
  - WAIT counter = 0;
  - state = FETCH.
REQ-025 After Reset falls, the first oValid=1 SHALL occur on the first rising edge, carrying ROM[P_RESET_PC].

Structure
REQ-026 Opcode constants (including NOP) and the FSM state encodings SHALL live in the shared definitions include file.
REQ-027 The WAIT counter SHALL be a single sub-module, delay_counter, with:
  - a load port;
  - a decrement enable;
  - a 24-bit load value;
  - a done flag.
REQ-028 All outputs SHALL be registered, except oAddress, which SHALL be driven directly from the PC register.

Verification
REQ-029 Reset then free-run, ROM words 0..3 = ADD instructions -> oValid=1 from the first edge, with oPC = 0,1,2,3 on consecutive cycles.
REQ-030 ROM[1] = NOP with N=5 -> NOP issues at oPC=1, oValid=0 for exactly 5 cycles, then oPC=2 issues.
REQ-031 iBranchTaken=1 with target 16'd6 at cycle 3, with iStall=1 in the same cycle -> one FLUSH cycle with oValid=0, then oPC=6.
REQ-032 iStall=1 held for 3 cycles during WAIT with N=4 -> total oValid=0 span of 7 cycles, and oInstruction unchanged throughout.
REQ-033 PC preset via branch to 16'hFFFF -> issues oPC=FFFF, then oPC=0000.
REQ-034 Reset asserted mid-WAIT, between clock edges -> outputs clear immediately (oValid=0, oPC=0), and fetch restarts at address 0.
